// File: rtl/dmem_pkg.sv
// Shared types and access-legality helpers for the RV32 data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0100,
    OP_LHU = 4'b0101,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic mis;
    case (func3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Legal ops are encoded as {write, func3}; everything else is a fault.
  function automatic logic is_legal_op(input logic write, input logic [2:0] func3);
    logic legal;
    case ({write, func3})
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half lane selection for loads (with extension) and lane merge for stores.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rdata,
  output logic [31:0] new_word
);

  logic [31:0] byte_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load extract: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    byte_sh_s = old_word >> {addr_lo, 3'b000};
    byte_s    = byte_sh_s[7:0];
    if (addr_lo[1]) begin
      half_s = old_word[31:16];
    end else begin
      half_s = old_word[15:0];
    end
    case (func3)
      F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rdata = {24'h000000, byte_s};
      F3_H:    rdata = {{16{half_s[15]}}, half_s};
      F3_HU:   rdata = {16'h0000, half_s};
      F3_W:    rdata = old_word;
      default: rdata = 32'h0000_0000;
    endcase
  end

  // Store merge: only the addressed lane changes.
  always_comb begin
    new_word = old_word;
    case (func3)
      F3_B: new_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) begin
          new_word[31:16] = wdata[15:0];
        end else begin
          new_word[15:0] = wdata[15:0];
        end
      end
      F3_W:    new_word = wdata;
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with a valid/ready load/store front end, configurable wait states
// and fault detection for misaligned, out-of-range and illegal accesses.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  lsu_state_e state_r, state_nxt_s;
  logic        write_r;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  func3_r, cnt_r;

  logic        accept_s, retire_s, enter_resp_s, fault_s;
  logic        cur_write_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic [2:0]  cur_func3_s;
  logic [IDX_W-1:0] cur_idx_s;
  logic [31:0] old_word_s, load_data_s, new_word_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  assign accept_s = (state_r == ST_IDLE) && req_valid;
  assign retire_s = rsp_valid && rsp_ready;

  // With zero wait states the commit happens on the accept edge, so the live request is used in IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_write_s = req_write;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
      cur_func3_s = req_func3;
    end else begin
      cur_write_s = write_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_func3_s = func3_r;
    end
  end

  assign cur_idx_s  = cur_addr_s[IDX_W+1:2];
  assign old_word_s = mem_r[cur_idx_s];
  assign fault_s    = is_misaligned(cur_func3_s, cur_addr_s[1:0])
                   || !is_legal_op(cur_write_s, cur_func3_s)
                   || ((cur_addr_s >> (IDX_W + 2)) != 32'd0);

  dmem_lane_align u_align (
    .old_word (old_word_s),
    .wdata    (cur_wdata_s),
    .func3    (cur_func3_s),
    .addr_lo  (cur_addr_s[1:0]),
    .rdata    (load_data_s),
    .new_word (new_word_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (retire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign enter_resp_s = (state_r != ST_RESP) && (state_nxt_s == ST_RESP);

  // State, request latch, wait counter and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_fault <= 1'b0;
      write_r   <= 1'b0;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      func3_r   <= 3'b000;
      cnt_r     <= 3'd0;
    end else begin
      state_r   <= state_nxt_s;
      req_ready <= (state_nxt_s == ST_IDLE);
      busy      <= (state_nxt_s != ST_IDLE);
      rsp_valid <= (state_r == ST_RESP) && !retire_s;
      if (accept_s) begin
        write_r <= req_write;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        func3_r <= req_func3;
        cnt_r   <= 3'd0;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + 3'd1;
      end
      if (enter_resp_s) begin
        rsp_fault <= fault_s;
        rsp_rdata <= (fault_s || cur_write_s) ? 32'h0000_0000 : load_data_s;
      end
    end
  end

  // Storage array; the RESP-entry edge is the single write point.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp_s && cur_write_s && !fault_s) begin
      mem_r[cur_idx_s] <= new_word_s;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: three instances (WAIT_CYCLES 1, 0, 7) driven one at a time.
module tb_dmem_lsu;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        fault;
    int          first_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid_a [3];
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_ready;
  logic        req_ready_w [3];
  logic        rsp_valid_w [3];
  logic [31:0] rsp_rdata_w [3];
  logic        rsp_fault_w [3];
  logic        busy_w [3];

  exp_t exp_q [$];
  int   tests;
  int   errors;
  int   cyc;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_lsu #(
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 7))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid_a[g]),
      .req_ready (req_ready_w[g]),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_func3 (req_func3),
      .rsp_valid (rsp_valid_w[g]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata_w[g]),
      .rsp_fault (rsp_fault_w[g]),
      .busy      (busy_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc_of(input int inst);
    return (inst == 0) ? 1 : ((inst == 1) ? 0 : 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input int inst);
    chk($sformatf("rst_rsp_valid%0d", inst), {31'd0, rsp_valid_w[inst]}, 32'd0);
    chk($sformatf("rst_req_ready%0d", inst), {31'd0, req_ready_w[inst]}, 32'd1);
    chk($sformatf("rst_busy%0d", inst), {31'd0, busy_w[inst]}, 32'd0);
    chk($sformatf("rst_rdata%0d", inst), rsp_rdata_w[inst], 32'd0);
    chk($sformatf("rst_fault%0d", inst), {31'd0, rsp_fault_w[inst]}, 32'd0);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  task automatic monitor_loop();
    bit seen [3];
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (rsp_valid_w[i]) begin
            if (exp_q.size() == 0 || exp_q[0].inst != i) begin
              tests++;
              errors++;
              $display("FAIL unexpected_rsp inst=%0d rdata=%h fault=%0b", i, rsp_rdata_w[i], rsp_fault_w[i]);
            end else begin
              if (!seen[i]) begin
                chk($sformatf("latency%0d", i), cyc, exp_q[0].first_cyc);
                seen[i] = 1'b1;
              end
              chk($sformatf("rdata%0d", i), rsp_rdata_w[i], exp_q[0].rdata);
              chk($sformatf("fault%0d", i), {31'd0, rsp_fault_w[i]}, {31'd0, exp_q[0].fault});
              chk($sformatf("req_ready_in_resp%0d", i), {31'd0, req_ready_w[i]}, 32'd0);
              chk($sformatf("busy_in_resp%0d", i), {31'd0, busy_w[i]}, 32'd1);
              if (rsp_ready) begin
                void'(exp_q.pop_front());
                seen[i] = 1'b0;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic issue(input int inst, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_fault);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_w[inst] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_w[inst]) begin
      tests++;
      errors++;
      $display("FAIL ready_timeout inst=%0d addr=%h", inst, addr);
    end else begin
      req_write          = wr;
      req_func3          = f3;
      req_addr           = addr;
      req_wdata          = wd;
      req_valid_a[inst]  = 1'b1;
      e.inst      = inst;
      e.rdata     = exp_rdata;
      e.fault     = exp_fault;
      e.first_cyc = cyc + 2 + wc_of(inst);
      exp_q.push_back(e);
      @(negedge clk);
      req_valid_a[inst] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Store/load round trip, extension and lane merge on one instance.
  task automatic run_basic(input int inst);
    issue(inst, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(inst, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(inst, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    issue(inst, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    issue(inst, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    issue(inst, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    issue(inst, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0);
    issue(inst, 1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h0, 1'b0);
    issue(inst, 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    issue(inst, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    issue(inst, 1'b0, 3'b000, 32'h11, 32'h0, 32'h00000055, 1'b0);
    issue(inst, 1'b0, 3'b001, 32'h10, 32'h0, 32'h000055EF, 1'b0);
    drain();
  endtask

  initial begin
    int n;
    tests     = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_func3 = 3'b000;
    for (int i = 0; i < 3; i++) req_valid_a[i] = 1'b0;
    fork
      monitor_loop();
    join_none
    #1;
    for (int i = 0; i < 3; i++) chk_reset_outputs(i);
    #21 rst = 1'b0;

    run_basic(0);

    // Faults leave storage untouched; last word is still in range.
    issue(0, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 3'b001, 32'h11, 32'h0000BEEF, 32'h0, 1'b1);
    issue(0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    issue(0, 1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(0, 1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);
    drain();

    // Back-pressure: response held five cycles, a stray request must be ignored.
    rsp_ready = 1'b0;
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    n = 0;
    while (!rsp_valid_w[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_w[0]) begin
      tests++;
      errors++;
      $display("FAIL rsp_valid_timeout inst=0");
    end
    req_write      = 1'b0;
    req_func3      = 3'b010;
    req_addr       = 32'h14;
    req_valid_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    req_valid_a[0] = 1'b0;
    rsp_ready      = 1'b1;
    drain();
    repeat (12) @(negedge clk);
    #1;
    chk("idle_busy0", {31'd0, busy_w[0]}, 32'd0);
    chk("idle_req_ready0", {31'd0, req_ready_w[0]}, 32'd1);

    // Reset during the wait state of a store aborts it.
    issue(0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    issue(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);
    drain();
    issue(0, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    @(negedge clk);
    #3 rst = 1'b0;
    issue(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);
    drain();

    run_basic(1);
    run_basic(2);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
